// File: rtl/alu_mul_sequencer.sv
// Unsigned shift-add multiplier that borrows the shared add_sub unit for one
// partial-product add per cycle; fixed WIDTH-cycle iteration, 2*WIDTH result.
module alu_mul_sequencer #(
  parameter int          WIDTH   = 32,
  parameter logic [2:0]  SEL_ADD = 3'b000,
  parameter int          CNT_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               prod_zero,
  output logic [2:0]         alu_select,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_carry
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               prod_zero_q, prod_zero_d;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mcand_d     = mcand_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    product_d   = product_q;
    prod_zero_d = prod_zero_q;
    alu_select  = SEL_ADD;
    alu_a       = '0;
    alu_b       = '0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = ITER;
          mcand_d  = op_a;
          acc_lo_d = op_b;
          acc_hi_d = '0;
          count_d  = '0;
        end else begin
          state_d  = IDLE;
        end
      end
      ITER: begin
        alu_a = acc_hi_q;
        alu_b = mcand_q;
        // The carry lands in the top bit as the accumulator shifts right,
        // so the WIDTH+1-bit sum never loses a bit.
        if (acc_lo_q[0])
          {acc_hi_d, acc_lo_d} = {alu_carry, alu_out, acc_lo_q[WIDTH-1:1]};
        else
          {acc_hi_d, acc_lo_d} = {1'b0, acc_hi_q, acc_lo_q[WIDTH-1:1]};
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST) begin
          state_d     = DONE;
          product_d   = {acc_hi_d, acc_lo_d};
          prod_zero_d = ~|{acc_hi_d, acc_lo_d};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      mcand_q     <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      product_q   <= '0;
      prod_zero_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mcand_q     <= mcand_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      product_q   <= product_d;
      prod_zero_q <= prod_zero_d;
    end
  end

  assign busy      = (state_q == ITER);
  assign done      = (state_q == DONE);
  assign product   = product_q;
  assign prod_zero = prod_zero_q;

endmodule
